// File: rtl/udp_loopback_buf_pkg.sv
// Shared types and constants for the UDP loopback ping-pong buffer.
// Sender FSM states, header sizes and the legal UDP length window.
package udp_pkg;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;

   localparam logic [3:0]  TX_IDLE_STATE     = 4'd0;
   localparam logic [15:0] IP_HDR_BYTES      = 16'd20;
   localparam logic [15:0] UDP_HDR_BYTES     = 16'd8;
   localparam logic [15:0] MAX_PAYLOAD_BYTES = 16'd2048;

   typedef enum logic [1:0] {
      T_IDLE,
      T_ARM,
      T_WAIT_BUSY,
      T_WAIT_DONE
   } tx_fsm_e;

   function automatic logic len_ok(input logic [15:0] len);
      return (len >= UDP_HDR_BYTES) &&
             (len <= MAX_PAYLOAD_BYTES + UDP_HDR_BYTES);
   endfunction

endpackage

// File: rtl/udp_loopback_buf_if.sv
// Receiver-side write port and sender-side read/control port of the buffer.
// The buffer takes the slave modport; the surrounding logic takes master.
interface udp_loopback_buf_if;
   import udp_pkg::*;

   logic              data_o_valid;
   logic [DATA_W-1:0] ram_wr_data;
   logic [ADDR_W-1:0] ram_wr_addr;
   logic [15:0]       rx_data_length;
   logic              data_receive;
   logic [3:0]        tx_state;
   logic [ADDR_W-1:0] ram_rd_addr;
   logic [DATA_W-1:0] ram_rd_data;
   logic [15:0]       tx_data_length;
   logic [15:0]       tx_total_length;
   logic              tx_start;
   logic [1:0]        buf_full;
   logic [15:0]       frame_drop_cnt;

   modport master (
      output data_o_valid, ram_wr_data, ram_wr_addr,
      output rx_data_length, data_receive, tx_state, ram_rd_addr,
      input  ram_rd_data, tx_data_length, tx_total_length,
      input  tx_start, buf_full, frame_drop_cnt
   );

   modport slave (
      input  data_o_valid, ram_wr_data, ram_wr_addr,
      input  rx_data_length, data_receive, tx_state, ram_rd_addr,
      output ram_rd_data, tx_data_length, tx_total_length,
      output tx_start, buf_full, frame_drop_cnt
   );

endinterface

// File: rtl/udp_loopback_buf_dpram.sv
// Simple dual-port RAM holding both banks, addressed as {bank, word}.
// One write port, one read port with a registered output.
module udp_buf_dpram #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata <= '0;
      else        rdata <= mem[raddr];
   end

endmodule

// File: rtl/udp_loopback_buf.sv
// Ping-pong payload buffer between the UDP receive path and the sender.
// One bank fills while the other is transmitted; at most two frames held.
module udp_loopback_buf
   import udp_pkg::*;
(
   input  logic              e_rxc,
   input  logic              reset_n,
   udp_loopback_buf_if.slave bus
);

   tx_fsm_e     st_q;
   logic [1:0]  buf_full_q;
   logic        wr_bank_q;
   logic        rd_bank_q;
   logic        last_bank_q;
   logic        frame_accept_q;
   logic [15:0] len_q [2];
   logic        tx_start_q;
   logic [15:0] tx_len_q;
   logic [15:0] tx_tot_q;
   logic [15:0] drop_cnt_q;

   logic       frame_start;
   logic       start_ok;
   logic       start_bank;
   logic       wr_acc;
   logic       wr_bank;
   logic       commit;
   logic       drop;
   logic       rel_bank;
   logic       pick;
   logic [1:0] set_mask;
   logic [1:0] clr_mask;

   // The bank under transmission stays full until release, so taking
   // the lowest empty bank can never land on the sender's bank.
   always_comb begin
      frame_start = bus.data_o_valid && (bus.ram_wr_addr == '0);
      start_ok    = ~&buf_full_q;
      start_bank  = buf_full_q[0];
      wr_acc      = frame_start ? start_ok : frame_accept_q;
      wr_bank     = (frame_start && start_ok) ? start_bank : wr_bank_q;
      commit      = bus.data_receive && frame_accept_q &&
                    len_ok(bus.rx_data_length);
      drop        = bus.data_receive && !commit;
      rel_bank    = (st_q == T_WAIT_DONE) &&
                    (bus.tx_state == TX_IDLE_STATE);
      pick        = (&buf_full_q) ? ~last_bank_q : buf_full_q[1];
      set_mask    = commit   ? (2'b01 << wr_bank_q) : 2'b00;
      clr_mask    = rel_bank ? (2'b01 << rd_bank_q) : 2'b00;
   end

   udp_buf_dpram #(
      .AW(ADDR_W + 1),
      .DW(DATA_W)
   ) u_ram (
      .clk  (e_rxc),
      .rst_n(reset_n),
      .we   (bus.data_o_valid && wr_acc),
      .waddr({wr_bank, bus.ram_wr_addr}),
      .wdata(bus.ram_wr_data),
      .raddr({rd_bank_q, bus.ram_rd_addr}),
      .rdata(bus.ram_rd_data)
   );

   always_ff @(posedge e_rxc or negedge reset_n) begin
      if (!reset_n) begin
         st_q           <= T_IDLE;
         buf_full_q     <= 2'b00;
         wr_bank_q      <= 1'b0;
         rd_bank_q      <= 1'b0;
         last_bank_q    <= 1'b0;
         frame_accept_q <= 1'b0;
         len_q[0]       <= '0;
         len_q[1]       <= '0;
         tx_start_q     <= 1'b0;
         tx_len_q       <= '0;
         tx_tot_q       <= '0;
         drop_cnt_q     <= '0;
      end else begin
         if (frame_start) begin
            frame_accept_q <= start_ok;
            if (start_ok) wr_bank_q <= start_bank;
         end
         if (bus.data_receive) frame_accept_q <= 1'b0;
         if (commit) begin
            len_q[wr_bank_q] <= bus.rx_data_length;
            last_bank_q      <= wr_bank_q;
         end
         if (drop && drop_cnt_q != 16'hFFFF)
            drop_cnt_q <= drop_cnt_q + 16'd1;
         buf_full_q <= (buf_full_q | set_mask) & ~clr_mask;

         unique case (st_q)
            T_IDLE: begin
               tx_start_q <= 1'b0;
               if (|buf_full_q) begin
                  rd_bank_q  <= pick;
                  tx_len_q   <= len_q[pick];
                  tx_tot_q   <= len_q[pick] + IP_HDR_BYTES;
                  tx_start_q <= 1'b1;
                  st_q       <= T_ARM;
               end
            end
            T_ARM: begin
               tx_start_q <= 1'b0;
               st_q       <= T_WAIT_BUSY;
            end
            T_WAIT_BUSY: begin
               if (bus.tx_state != TX_IDLE_STATE) st_q <= T_WAIT_DONE;
            end
            T_WAIT_DONE: begin
               if (rel_bank) st_q <= T_IDLE;
            end
            default: st_q <= T_IDLE;
         endcase
      end
   end

   assign bus.tx_start        = tx_start_q;
   assign bus.tx_data_length  = tx_len_q;
   assign bus.tx_total_length = tx_tot_q;
   assign bus.buf_full        = buf_full_q;
   assign bus.frame_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_udp_loopback_buf.sv
// Scoreboard bench for udp_loopback_buf: frames are modelled as queues,
// expected lengths and read words are queued and checked by a monitor.
module tb_udp_loopback_buf;
   import udp_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #4 clk = ~clk;

   udp_loopback_buf_if bus();

   udp_loopback_buf dut (
      .e_rxc  (clk),
      .reset_n(rst_n),
      .bus    (bus)
   );

   int total = 0;
   int bad = 0;

   int          outstanding = 0;
   int          drops = 0;
   int          start_cnt = 0;
   int          served = 0;
   int          pend_n[$];
   logic [31:0] pend_salt[$];
   logic [15:0] pend_len[$];
   logic [15:0] exp_tx[$];
   logic [31:0] exp_rd[$];
   bit          rd_req = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] wgen(input logic [31:0] salt,
                                        input int i);
      return salt ^ (32'(i) * 32'h9E37_79B9);
   endfunction

   function automatic bit legal(input int len);
      return len >= 8 && len <= 2048 + 8;
   endfunction

   // Monitor: one cycle after each requested read, and on every tx_start.
   always @(posedge clk) begin
      logic [31:0] e;
      logic [15:0] l;
      #1;
      if (rst_n) begin
         if (rd_req) begin
            if (exp_rd.size() == 0) begin
               total++; bad++;
               $display("FAIL rd_data: no expected word queued");
            end else begin
               e = exp_rd.pop_front();
               chk("rd_data", bus.ram_rd_data, e);
            end
         end
         if (bus.tx_start) begin
            start_cnt++;
            if (exp_tx.size() == 0) begin
               total++; bad++;
               $display("FAIL tx_start: got unexpected pulse, want none (len %0d)",
                        bus.tx_data_length);
            end else begin
               l = exp_tx.pop_front();
               chk("tx_data_length", 32'(bus.tx_data_length), 32'(l));
               chk("tx_total_length", 32'(bus.tx_total_length),
                   32'(l) + 32'd20);
            end
         end
      end
   end

   task automatic model_release();
      void'(pend_n.pop_front());
      void'(pend_salt.pop_front());
      void'(pend_len.pop_front());
      outstanding--;
      served++;
   endtask

   task automatic rx_frame(input int n, input int len, input bit rel = 1'b0);
      logic [31:0] salt;
      bit acc;
      salt = $urandom;
      acc = (outstanding < 2);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.data_o_valid = 1'b1;
         bus.ram_wr_addr  = 9'(i);
         bus.ram_wr_data  = wgen(salt, i);
      end
      @(negedge clk);
      bus.data_o_valid   = 1'b0;
      bus.data_receive   = 1'b1;
      bus.rx_data_length = 16'(len);
      if (rel) bus.tx_state = 4'd0;
      @(negedge clk);
      bus.data_receive = 1'b0;
      if (rel) model_release();
      if (acc && legal(len)) begin
         outstanding++;
         pend_n.push_back(n);
         pend_salt.push_back(salt);
         pend_len.push_back(16'(len));
         exp_tx.push_back(16'(len));
      end else if (drops < 65535) begin
         drops++;
      end
      chk("frame_drop_cnt", 32'(bus.frame_drop_cnt), 32'(drops));
      chk("occupancy", 32'($countones(bus.buf_full)), 32'(outstanding));
   endtask

   task automatic serve_begin();
      int t;
      t = 0;
      while (start_cnt <= served && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("tx_start_seen", 32'(start_cnt), 32'(served + 1));
      bus.tx_state = 4'($urandom_range(1, 15));
      repeat (2) @(negedge clk);
   endtask

   task automatic serve_read();
      int n;
      int a;
      n = pend_n[0];
      chk("tx_len_hold", 32'(bus.tx_data_length), 32'(pend_len[0]));
      chk("tx_tot_hold", 32'(bus.tx_total_length),
          32'(pend_len[0]) + 32'd20);
      for (int k = 0; k < n + 3; k++) begin
         a = (k < n) ? k : $urandom_range(0, n - 1);
         @(negedge clk);
         bus.ram_rd_addr = 9'(a);
         rd_req = 1'b1;
         exp_rd.push_back(wgen(pend_salt[0], a));
      end
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   task automatic serve_end();
      @(negedge clk);
      bus.tx_state = 4'd0;
      @(negedge clk);
      model_release();
      chk("occupancy_rel", 32'($countones(bus.buf_full)),
          32'(outstanding));
   endtask

   task automatic serve();
      serve_begin();
      serve_read();
      serve_end();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
      chk({tag, "_tx_len"}, 32'(bus.tx_data_length), 32'd0);
      chk({tag, "_tx_tot"}, 32'(bus.tx_total_length), 32'd0);
      chk({tag, "_buf_full"}, 32'(bus.buf_full), 32'd0);
      chk({tag, "_drop_cnt"}, 32'(bus.frame_drop_cnt), 32'd0);
      chk({tag, "_rd_data"}, bus.ram_rd_data, 32'd0);
   endtask

   initial begin
      int r;
      int len;
      bus.data_o_valid   = 1'b0;
      bus.ram_wr_data    = '0;
      bus.ram_wr_addr    = '0;
      bus.rx_data_length = '0;
      bus.data_receive   = 1'b0;
      bus.tx_state       = 4'd0;
      bus.ram_rd_addr    = '0;

      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Single 16-word frame
      rx_frame(16, 72);
      chk("first_bank", 32'(bus.buf_full), 32'd1);
      serve();
      chk("first_free", 32'(bus.buf_full), 32'd0);

      // Two frames held, third dropped without touching either bank
      rx_frame(10, 100);
      serve_begin();
      rx_frame(12, 300);
      chk("both_full", 32'(bus.buf_full), 32'd3);
      rx_frame(8, 64);
      chk("drop_third", 32'(bus.frame_drop_cnt), 32'd1);
      serve_read();
      serve_end();
      serve();

      // Length window edges
      rx_frame(4, 4);
      rx_frame(4, 2100);
      rx_frame(2, 7);
      rx_frame(2, 2057);
      repeat (5) @(negedge clk);
      chk("bad_len_empty", 32'(bus.buf_full), 32'd0);
      rx_frame(3, 8);
      serve();
      rx_frame(3, 2056);
      serve();

      // Release and commit in the same cycle
      rx_frame(6, 120);
      serve_begin();
      serve_read();
      rx_frame(9, 200, 1'b1);
      serve();

      // Reset while waiting for the sender to finish
      rx_frame(5, 80);
      serve_begin();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_zero("midreset");
      exp_tx.delete();
      exp_rd.delete();
      pend_n.delete();
      pend_salt.delete();
      pend_len.delete();
      outstanding = 0;
      drops = 0;
      start_cnt = 0;
      served = 0;
      bus.tx_state = 4'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("no_reissue", 32'(start_cnt), 32'd0);
      rx_frame(16, 72);
      chk("post_reset_bank", 32'(bus.buf_full), 32'd1);
      serve();

      // Random traffic
      for (int it = 0; it < 80; it++) begin
         if (outstanding > 0 && $urandom_range(0, 2) == 0) begin
            serve();
         end else begin
            r = $urandom_range(0, 9);
            if (r == 0)      len = $urandom_range(0, 7);
            else if (r == 1) len = $urandom_range(2057, 65535);
            else             len = $urandom_range(8, 2056);
            rx_frame($urandom_range(1, 24), len);
         end
      end
      while (outstanding > 0) serve();
      repeat (5) @(negedge clk);
      chk("exp_tx_drained", 32'(exp_tx.size()), 32'd0);
      chk("exp_rd_drained", 32'(exp_rd.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
